alu_seq: RTL and testbench

Parametrised, registered ALU that replaces the 8-bit combinational add/sub ALU. It adds carry-chained arithmetic, logic ops, iterative multi-cycle shifts and a persistent flag register. Results and flags are registered. Handshake is valid/ready, so the block can sit directly between the register file and the writeback stage of the CPU datapath.

---
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_seq.sv | 122 ++++++++++++
 tb/tb_alu_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands and op go in, registered result/flags come out.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             out_valid;
  logic             busy;

  modport master (
    output in_valid, op, a, b,
    input  in_ready, result, flags, out_valid, busy
  );

  modport slave (
    input  in_valid, op, a, b,
    output in_ready, result, flags, out_valid, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with carry-chained arithmetic, logic ops, one-bit-per-cycle shifts
// and a persistent {N,Z,C,V} flag register.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_ADC = 3'b010,
    OP_SBC = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state;
  logic [WIDTH-1:0] shreg;
  logic [SHW-1:0]   cnt;
  logic             dir;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic             op_v;
  logic             is_shift;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] shift_next;
  logic             shift_out;

  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state == SHIFT);
  assign bus.in_ready  = (state != SHIFT);

  assign is_shift = bus.op[2] & bus.op[1];
  assign amt      = bus.b[SHW-1:0];

  // op[0] selects subtraction (invert b), op[1] selects the stored carry as carry-in.
  always_comb begin
    b_eff = bus.op[0] ? ~bus.b : bus.b;
    cin   = bus.op[1] ? flags_q[1] : bus.op[0];
    sum   = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    op_res = bus.a;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (op_e'(bus.op))
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        op_res = sum[WIDTH-1:0];
        op_c   = sum[WIDTH];
        op_v   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND:  op_res = bus.a & bus.b;
      OP_OR:   op_res = bus.a | bus.b;
      default: op_res = bus.a;
    endcase
  end

  // dir=1 is SHR; the bit falling off the end becomes C on the final step.
  always_comb begin
    shift_next = dir ? (shreg >> 1) : (shreg << 1);
    shift_out  = dir ? shreg[0] : shreg[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      dir         <= 1'b0;
      result_q    <= '0;
      flags_q     <= 4'b0000;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_shift && (amt != '0)) begin
              shreg <= bus.a;
              cnt   <= amt;
              dir   <= bus.op[0];
              state <= SHIFT;
            end else begin
              result_q    <= op_res;
              flags_q     <= {op_res[WIDTH-1], (op_res == '0), op_c, op_v};
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          shreg <= shift_next;
          cnt   <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result_q    <= shift_next;
            flags_q     <= {shift_next[WIDTH-1], (shift_next == '0), shift_out, 1'b0};
            out_valid_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table for single-cycle ops plus hand sequences for shifts and reset.
module tb_alu_seq;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, ADC = 3'b010, SBC = 3'b011;
  localparam logic [2:0] AND = 3'b100, OR  = 3'b101, SHL = 3'b110, SHR = 3'b111;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  vec_t vecs[16];

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_output(input string name, input logic [7:0] res, input logic [3:0] flg,
                              input logic vld);
    check_val({name, ".result"}, 32'(bus.result), 32'(res));
    check_val({name, ".flags"}, 32'(bus.flags), 32'(flg));
    check_val({name, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
  endtask

  // Presents one request for exactly one rising edge, then samples 1 ns after it.
  task automatic apply_stimulus(input logic [2:0] op_i, input logic [7:0] a_i, input logic [7:0] b_i);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op_i;
    bus.a        = a_i;
    bus.b        = b_i;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int lat;
    bit seen;
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.op       = 3'b000;
    bus.a        = 8'h00;
    bus.b        = 8'h00;

    // Flags are {N,Z,C,V}; vectors run back-to-back so C chains into ADC/SBC.
    vecs[0]  = '{"add_123_8",   ADD, 8'd123, 8'd8,   8'd131, 4'b1001};
    vecs[1]  = '{"sub_5_7",     SUB, 8'd5,   8'd7,   8'd254, 4'b1000};
    vecs[2]  = '{"sub_7_7",     SUB, 8'd7,   8'd7,   8'd0,   4'b0110};
    vecs[3]  = '{"add_200_100", ADD, 8'd200, 8'd100, 8'd44,  4'b0010};
    vecs[4]  = '{"adc_1_1_c1",  ADC, 8'd1,   8'd1,   8'd3,   4'b0000};
    vecs[5]  = '{"and_f0_3c",   AND, 8'hF0,  8'h3C,  8'h30,  4'b0000};
    vecs[6]  = '{"or_80_01",    OR,  8'h80,  8'h01,  8'h81,  4'b1000};
    vecs[7]  = '{"and_zero",    AND, 8'h0F,  8'hF0,  8'h00,  4'b0100};
    vecs[8]  = '{"add_127_1",   ADD, 8'd127, 8'd1,   8'd128, 4'b1001};
    vecs[9]  = '{"sub_128_1",   SUB, 8'd128, 8'd1,   8'd127, 4'b0011};
    vecs[10] = '{"sbc_10_3_c1", SBC, 8'd10,  8'd3,   8'd7,   4'b0010};
    vecs[11] = '{"sbc_3_5_c1",  SBC, 8'd3,   8'd5,   8'd254, 4'b1000};
    vecs[12] = '{"sbc_5_2_c0",  SBC, 8'd5,   8'd2,   8'd2,   4'b0010};
    vecs[13] = '{"adc_ff_0_c1", ADC, 8'hFF,  8'h00,  8'h00,  4'b0110};
    vecs[14] = '{"shl_amt0",    SHL, 8'h5A,  8'h08,  8'h5A,  4'b0000};
    vecs[15] = '{"shr_amt0",    SHR, 8'h80,  8'h00,  8'h80,  4'b1000};

    repeat (2) @(posedge clk);
    #1;
    check_output("reset", 8'h00, 4'b0000, 1'b0);
    check_val("reset.busy", 32'(bus.busy), 32'd0);
    check_val("reset.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      check_output(vecs[i].name, vecs[i].res, vecs[i].flg, 1'b1);
    end

    @(posedge clk);
    #1;
    check_output("idle_hold", 8'h80, 4'b1000, 1'b0);

    $display("[TB] SHL 0x81 by 3 with an ignored request while busy");
    apply_stimulus(SHL, 8'h81, 8'd3);
    check_output("shl3_n", 8'h80, 4'b1000, 1'b0);
    check_val("shl3_n.busy", 32'(bus.busy), 32'd1);
    check_val("shl3_n.in_ready", 32'(bus.in_ready), 32'd0);
    apply_stimulus(ADD, 8'd1, 8'd1);
    check_output("shl3_n1", 8'h80, 4'b1000, 1'b0);
    check_val("shl3_n1.busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    check_val("shl3_n2.out_valid", 32'(bus.out_valid), 32'd0);
    check_val("shl3_n2.busy", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    check_output("shl3_n3", 8'h08, 4'b0000, 1'b1);
    check_val("shl3_n3.busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check_output("shl3_n4", 8'h08, 4'b0000, 1'b0);

    apply_stimulus(SHR, 8'h81, 8'd1);
    check_val("shr1_n.busy", 32'(bus.busy), 32'd1);
    check_val("shr1_n.out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_output("shr1_n1", 8'h40, 4'b0010, 1'b1);

    $display("[TB] SHL 0x01 by 7 (maximum latency)");
    apply_stimulus(SHL, 8'h01, 8'd7);
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid) seen = 1'b1;
    end
    check_val("shl7.latency", 32'(lat), 32'd7);
    check_output("shl7", 8'h80, 4'b1000, 1'b1);

    $display("[TB] reset in the middle of SHR 0xFF by 7");
    apply_stimulus(SHR, 8'hFF, 8'd7);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("mid_reset", 8'h00, 4'b0000, 1'b0);
    check_val("mid_reset.busy", 32'(bus.busy), 32'd0);
    check_val("mid_reset.in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_val("mid_reset_hold.out_valid", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(ADD, 8'd1, 8'd1);
    check_output("post_reset_add", 8'd2, 4'b0000, 1'b1);
    apply_stimulus(ADC, 8'd1, 8'd1);
    check_output("post_reset_adc", 8'd2, 4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
